bclksclk_train_sched: RTL and testbench
=======================================

BCLKSCLK_TRAIN_SCHED -- requirements
Module: bclksclk_train_sched

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4: number of lanes sharing one BCLK/SCLK alignment training engine (range 2..16).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 8: number of cycles between a lane-select change and the TRAIN_START pulse (range 1..255).
REQ-003 SHALL have parameter TMO_W, default 16: width of the done-timeout counter; timeout occurs at 2^TMO_W-1 cycles.
REQ-004 SHALL have parameter MAX_RETRY, default 2: number of restarts allowed per grant before the lane fails.
REQ-005 SHALL have port SCLK, input, 1 bit: system clock; the block's one clock; rising edge.
REQ-006 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port LANE_TRAIN_REQ, input, NUM_LANES bits: level per lane, held until that lane's ACK.
REQ-008 SHALL have port LANE_TRAIN_ACK, output, NUM_LANES bits: one-cycle completion pulse to the granted lane.
REQ-009 SHALL have port LANE_TRAIN_ERR, output, NUM_LANES bits: sticky per-lane failure flag; cleared when that lane is granted again.
REQ-010 SHALL have port LANE_SEL, output, clog2(NUM_LANES) bits: engine mux select, index of the granted lane.
REQ-011 SHALL have port TRAIN_START, output, 1 bit: one-cycle start pulse to the training engine.
REQ-012 SHALL have port TRAIN_DONE, input, 1 bit: engine done level.
REQ-013 SHALL have port ALGN_ERR, input, 1 bit: engine error, sampled in the cycle TRAIN_DONE rises.
REQ-014 SHALL have port ALGN_RSTRT, output, 1 bit: one-cycle restart pulse to the engine.
REQ-015 SHALL have port SCHED_HOLD, input, 1 bit: when high, no new grant is issued.
REQ-016 SHALL have port BUSY, output, 1 bit: high in every state except IDLE.

Function
REQ-017 SHALL implement the states IDLE, SETTLE, START, WAIT_DONE, RESTART and COMPLETE.
REQ-018 In IDLE, SHALL move to SETTLE when any LANE_TRAIN_REQ bit is high and SCHED_HOLD is low.
REQ-019 On the IDLE-to-SETTLE transition, SHALL load LANE_SEL with the round-robin winner, search starting at last_grant+1 and wrapping modulo NUM_LANES.
REQ-020 On the same transition, SHALL clear the winner's LANE_TRAIN_ERR bit.
REQ-021 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then move to START.
REQ-022 START SHALL last 1 cycle with TRAIN_START=1, then move to WAIT_DONE with the timeout counter cleared.
REQ-023 WAIT_DONE SHALL detect the TRAIN_DONE rising edge using a registered previous value, so a done level left over from a prior lane is ignored.
REQ-024 On that rising edge with ALGN_ERR=0, SHALL move to COMPLETE.
REQ-025 On that rising edge with ALGN_ERR=1, or when the counter reaches 2^TMO_W-1, SHALL treat the attempt as failed.
REQ-026 On a failed attempt with retry_cnt<MAX_RETRY, SHALL move to RESTART, increment retry_cnt, and hold LANE_SEL unchanged.
REQ-027 On a failed attempt with retry_cnt=MAX_RETRY, SHALL set LANE_TRAIN_ERR[LANE_SEL] and move to COMPLETE.
REQ-028 RESTART SHALL last 1 cycle with ALGN_RSTRT=1, then move to SETTLE.
REQ-029 COMPLETE SHALL last 1 cycle with LANE_TRAIN_ACK[LANE_SEL]=1, update last_grant, clear retry_cnt, and move to IDLE.
REQ-030 Grant-to-start latency SHALL be SETTLE_CYCLES+1 cycles from the IDLE exit.
REQ-031 The ACK pulse SHALL follow a good TRAIN_DONE edge by exactly 1 cycle.
REQ-032 A lane whose request drops mid-grant SHALL still be run to COMPLETE; no abort.
REQ-033 SCHED_HOLD SHALL affect only IDLE; an active grant always finishes.
REQ-034 With simultaneous requests, no lane SHALL wait more than NUM_LANES-1 grants.
REQ-035 TRAIN_DONE together with timeout in the same cycle SHALL count as a done edge; the done edge takes priority.
REQ-036 The timeout counter SHALL saturate, never wrap.

Reset
REQ-037 RESET SHALL asynchronously force IDLE, clear all counters, set LANE_SEL=0 and last_grant=NUM_LANES-1 (so lane 0 wins first), and drive all outputs low, including LANE_TRAIN_ERR.
REQ-038 A reset during any state SHALL abandon the grant with no ACK issued.
REQ-039 After RESET deasserts, the first grant SHALL be evaluated on the first SCLK rising edge.

Structure
REQ-040 A shared package SHALL hold the state enum and the default parameter constants; no typedef SHALL be local to the module.
REQ-041 The round-robin priority selector SHALL be one sub-module, bclksclk_rr_arb (inputs: request vector, last_grant; outputs: winner index, valid).

Verification
REQ-042 Reset, then LANE_TRAIN_REQ=4'b0001 with TRAIN_DONE rising 20 cycles after TRAIN_START -> LANE_SEL=0, TRAIN_START 9 cycles after IDLE exit, LANE_TRAIN_ACK=4'b0001 one cycle after the done edge, LANE_TRAIN_ERR=0.
REQ-043 LANE_TRAIN_REQ=4'b1111 held, each lane ACKs as granted -> grant order 0,1,2,3,0; BUSY low for exactly 1 cycle between grants.
REQ-044 Lane 2 sees ALGN_ERR=1 at every done edge -> 2 ALGN_RSTRT pulses, 3 TRAIN_START pulses, then ACK[2] with LANE_TRAIN_ERR[2]=1; the next grant of lane 2 clears the flag.
REQ-045 TRAIN_DONE held low with TMO_W=4 -> failure after 15 cycles in WAIT_DONE; retries as in REQ-044.
REQ-046 SCHED_HOLD=1 raised mid-WAIT_DONE -> the current lane still ACKs, and no new grant is issued until SCHED_HOLD=0.
REQ-047 RESET asserted in SETTLE, then released -> outputs low immediately, no ACK issued, and lane 0 is granted first after release.

Source files
------------

// File: rtl/bclksclk_train_sched_pkg.sv
// Shared types and default constants for the BCLK/SCLK alignment training scheduler.
package bclksclk_train_sched_pkg;

    localparam int DEF_NUM_LANES     = 4;
    localparam int DEF_SETTLE_CYCLES = 8;
    localparam int DEF_TMO_W         = 16;
    localparam int DEF_MAX_RETRY     = 2;

    // Width of the settle and retry counters; both limits fit in 8 bits.
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESTART   = 3'd4,
        ST_COMPLETE  = 3'd5
    } train_state_e;

endpackage

// File: rtl/bclksclk_train_sched_rr_arb.sv
// Round-robin lane picker: searches upward from last_grant+1, wrapping at NUM_LANES.
module bclksclk_rr_arb
    import bclksclk_train_sched_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int SEL_W     = $clog2(DEF_NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] req_vec,
    input  logic [SEL_W-1:0]     last_grant,
    output logic [SEL_W-1:0]     winner,
    output logic                 valid
);

    int               cand_s;
    logic [SEL_W-1:0] cand_idx_s;

    // First requesting lane after last_grant, in circular order.
    always_comb begin
        winner     = '0;
        valid      = 1'b0;
        cand_s     = 0;
        cand_idx_s = '0;
        for (int i = 1; i <= NUM_LANES; i++) begin
            cand_s = int'(last_grant) + i;
            if (cand_s >= NUM_LANES) begin
                cand_s = cand_s - NUM_LANES;
            end else begin
                cand_s = cand_s;
            end
            cand_idx_s = SEL_W'(cand_s);
            if (!valid && req_vec[cand_idx_s]) begin
                winner = cand_idx_s;
                valid  = 1'b1;
            end else begin
                valid  = valid;
            end
        end
    end

endmodule

// File: rtl/bclksclk_train_sched.sv
// Shares one BCLK/SCLK alignment training engine among several lanes, with
// settle delay, done-edge detection, timeout, bounded retries and sticky errors.
module bclksclk_train_sched
    import bclksclk_train_sched_pkg::*;
#(
    parameter int NUM_LANES     = DEF_NUM_LANES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int TMO_W         = DEF_TMO_W,
    parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
    input  logic                         SCLK,
    input  logic                         RESET,
    input  logic [NUM_LANES-1:0]         LANE_TRAIN_REQ,
    output logic [NUM_LANES-1:0]         LANE_TRAIN_ACK,
    output logic [NUM_LANES-1:0]         LANE_TRAIN_ERR,
    output logic [$clog2(NUM_LANES)-1:0] LANE_SEL,
    output logic                         TRAIN_START,
    input  logic                         TRAIN_DONE,
    input  logic                         ALGN_ERR,
    output logic                         ALGN_RSTRT,
    input  logic                         SCHED_HOLD,
    output logic                         BUSY
);

    localparam int               SEL_W       = $clog2(NUM_LANES);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RETRY_MAX   = CNT_W'(MAX_RETRY);
    localparam logic [TMO_W-1:0] TMO_MAX     = {TMO_W{1'b1}};
    localparam logic [SEL_W-1:0] LAST_LANE   = SEL_W'(NUM_LANES - 1);

    train_state_e           state_q, state_d;
    logic [CNT_W-1:0]       settle_cnt_q, settle_cnt_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [CNT_W-1:0]       retry_q, retry_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [SEL_W-1:0]       last_grant_q, last_grant_d;
    logic [NUM_LANES-1:0]   err_q, err_d;
    logic [NUM_LANES-1:0]   ack_q, ack_d;
    logic                   start_q, start_d;
    logic                   rstrt_q, rstrt_d;
    logic                   busy_q, busy_d;
    logic                   done_prev_q;

    logic [SEL_W-1:0]       win_idx_s;
    logic                   win_vld_s;
    logic                   grant_s;
    logic                   done_rise_s;
    logic [TMO_W-1:0]       tmo_inc_s;
    logic                   timeout_s;
    logic                   good_s;
    logic                   fail_s;
    logic                   retry_left_s;

    bclksclk_rr_arb #(
        .NUM_LANES (NUM_LANES),
        .SEL_W     (SEL_W)
    ) u_rr_arb (
        .req_vec    (LANE_TRAIN_REQ),
        .last_grant (last_grant_q),
        .winner     (win_idx_s),
        .valid      (win_vld_s)
    );

    // A done level carried over from a previous lane never counts as an edge.
    assign done_rise_s  = TRAIN_DONE & ~done_prev_q;
    assign tmo_inc_s    = (tmo_q == TMO_MAX) ? TMO_MAX : (tmo_q + TMO_W'(1));
    assign timeout_s    = (tmo_inc_s == TMO_MAX);
    assign grant_s      = (state_q == ST_IDLE) && win_vld_s && !SCHED_HOLD;
    assign good_s       = (state_q == ST_WAIT_DONE) && done_rise_s && !ALGN_ERR;
    assign fail_s       = (state_q == ST_WAIT_DONE) && (done_rise_s ? ALGN_ERR : timeout_s);
    assign retry_left_s = (retry_q < RETRY_MAX);

    // State and datapath registers.
    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            tmo_q        <= '0;
            retry_q      <= '0;
            sel_q        <= '0;
            last_grant_q <= LAST_LANE;
            err_q        <= '0;
            ack_q        <= '0;
            start_q      <= 1'b0;
            rstrt_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            tmo_q        <= tmo_d;
            retry_q      <= retry_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
            ack_q        <= ack_d;
            start_q      <= start_d;
            rstrt_q      <= rstrt_d;
            busy_q       <= busy_d;
            done_prev_q  <= TRAIN_DONE;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_START:   state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (good_s) begin
                    state_d = ST_COMPLETE;
                end else if (fail_s) begin
                    state_d = retry_left_s ? ST_RESTART : ST_COMPLETE;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_RESTART:  state_d = ST_SETTLE;
            ST_COMPLETE: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Counters, lane select and sticky error flags.
    always_comb begin
        settle_cnt_d = '0;
        tmo_d        = '0;
        retry_d      = retry_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        err_d        = err_q;

        if (state_q == ST_SETTLE) begin
            settle_cnt_d = settle_cnt_q + CNT_W'(1);
        end else begin
            settle_cnt_d = '0;
        end

        if (state_q == ST_WAIT_DONE) begin
            tmo_d = tmo_inc_s;
        end else begin
            tmo_d = '0;
        end

        if (fail_s && retry_left_s) begin
            retry_d = retry_q + CNT_W'(1);
        end else if (state_q == ST_COMPLETE) begin
            retry_d = '0;
        end else begin
            retry_d = retry_q;
        end

        if (grant_s) begin
            sel_d            = win_idx_s;
            err_d[win_idx_s] = 1'b0;
        end else if (fail_s && !retry_left_s) begin
            err_d[sel_q]     = 1'b1;
        end else begin
            sel_d            = sel_q;
        end

        if (state_q == ST_COMPLETE) begin
            last_grant_d = sel_q;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Outputs decoded from the upcoming state so they register in step with it.
    always_comb begin
        start_d = (state_d == ST_START);
        rstrt_d = (state_d == ST_RESTART);
        busy_d  = (state_d != ST_IDLE);
        ack_d   = '0;
        if (state_d == ST_COMPLETE) begin
            ack_d[sel_d] = 1'b1;
        end else begin
            ack_d = '0;
        end
    end

    assign LANE_TRAIN_ACK = ack_q;
    assign LANE_TRAIN_ERR = err_q;
    assign LANE_SEL       = sel_q;
    assign TRAIN_START    = start_q;
    assign ALGN_RSTRT     = rstrt_q;
    assign BUSY           = busy_q;

endmodule

// File: tb/tb_bclksclk_train_sched.sv
// Directed bench for bclksclk_train_sched: grant order, latency, retries, hold, reset, timeout.
module tb_bclksclk_train_sched;

    localparam int DONE_DLY = 20;

    logic       sclk = 1'b0;
    logic       rst;
    logic [3:0] req, ack, err;
    logic [1:0] sel;
    logic       start, done, algn_err, rstrt, hold, busy;
    logic [3:0] req2, ack2, err2;
    logic [1:0] sel2;
    logic       start2, rstrt2, busy2;

    int n_vec = 0;
    int n_bad = 0;

    logic [3:0] r_ack, r_err;
    logic [1:0] r_sel;
    int         r_starts, r_rstrts, r_lat, r_idle, r_ack_lat;
    int         exp_order [5] = '{0, 1, 2, 3, 0};

    always #5 sclk = ~sclk;

    bclksclk_train_sched #(
        .NUM_LANES(4), .SETTLE_CYCLES(8), .TMO_W(16), .MAX_RETRY(2)
    ) u_dut (
        .SCLK(sclk), .RESET(rst), .LANE_TRAIN_REQ(req), .LANE_TRAIN_ACK(ack),
        .LANE_TRAIN_ERR(err), .LANE_SEL(sel), .TRAIN_START(start), .TRAIN_DONE(done),
        .ALGN_ERR(algn_err), .ALGN_RSTRT(rstrt), .SCHED_HOLD(hold), .BUSY(busy)
    );

    bclksclk_train_sched #(
        .NUM_LANES(4), .SETTLE_CYCLES(8), .TMO_W(4), .MAX_RETRY(2)
    ) u_dut_tmo (
        .SCLK(sclk), .RESET(rst), .LANE_TRAIN_REQ(req2), .LANE_TRAIN_ACK(ack2),
        .LANE_TRAIN_ERR(err2), .LANE_SEL(sel2), .TRAIN_START(start2), .TRAIN_DONE(1'b0),
        .ALGN_ERR(1'b0), .ALGN_RSTRT(rstrt2), .SCHED_HOLD(1'b0), .BUSY(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_outs_low(input string tag);
        chk({tag, "_busy"},  32'(busy),  32'd0);
        chk({tag, "_ack"},   32'(ack),   32'd0);
        chk({tag, "_err"},   32'(err),   32'd0);
        chk({tag, "_sel"},   32'(sel),   32'd0);
        chk({tag, "_start"}, 32'(start), 32'd0);
        chk({tag, "_rstrt"}, 32'(rstrt), 32'd0);
    endtask

    // Acts as the training engine for one grant: raises done DONE_DLY cycles
    // after each TRAIN_START, dropping any leftover done level first.
    task automatic serve(input logic err_in, input logic hold_mid);
        int   dcnt, since, cyc;
        logic got;
        dcnt = -1; since = 0; cyc = 0; got = 1'b0;
        r_starts = 0; r_rstrts = 0; r_lat = 0; r_idle = 0; r_ack_lat = 0;
        r_ack = 4'd0; r_sel = 2'd0; r_err = 4'd0;
        while (!got && cyc < 600) begin
            @(negedge sclk);
            cyc++;
            since++;
            if (!busy && r_starts == 0 && r_lat == 0) r_idle++;
            if (busy && r_starts == 0) r_lat++;
            if (start) begin
                r_starts++;
                dcnt  = DONE_DLY;
                since = 0;
            end else if (dcnt > 0) begin
                dcnt--;
                if (dcnt == DONE_DLY - 3) done = 1'b0;
                if (dcnt == 0) begin
                    done     = 1'b1;
                    algn_err = err_in;
                    dcnt     = -1;
                end
            end
            if (hold_mid && r_starts > 0 && since == 5) hold = 1'b1;
            if (rstrt) begin
                r_rstrts++;
                done     = 1'b0;
                algn_err = 1'b0;
            end
            if (ack != 4'd0) begin
                got       = 1'b1;
                r_ack     = ack;
                r_sel     = sel;
                r_err     = err;
                r_ack_lat = since;
            end
        end
        chk("ack_seen", 32'(got), 32'd1);
    endtask

    initial begin
        int w, busy_cnt, starts2, rstrts2, t_start, gap, cyc;
        logic got2;
        logic [3:0] a2, e2;

        rst = 1'b1; req = 4'd0; done = 1'b0; algn_err = 1'b0; hold = 1'b0; req2 = 4'd0;
        repeat (2) @(negedge sclk);
        chk_outs_low("reset");
        rst = 1'b0;

        // Single lane, clean run.
        req = 4'b0001;
        serve(1'b0, 1'b0);
        chk("one_lat",     32'(r_lat),     32'd9);
        chk("one_sel",     32'(r_sel),     32'd0);
        chk("one_ack",     32'(r_ack),     32'h1);
        chk("one_err",     32'(r_err),     32'h0);
        chk("one_starts",  32'(r_starts),  32'd1);
        chk("one_ack_lat", 32'(r_ack_lat), 32'd21);
        req = 4'd0; done = 1'b0;

        // Fresh reset, all lanes requesting continuously.
        @(negedge sclk); rst = 1'b1;
        @(negedge sclk); rst = 1'b0;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            serve(1'b0, 1'b0);
            chk("rr_sel",     32'(r_sel),     32'(exp_order[g]));
            chk("rr_ack",     32'(r_ack),     32'd1 << exp_order[g]);
            chk("rr_ack_lat", 32'(r_ack_lat), 32'd21);
            if (g > 0) chk("rr_idle_gap", 32'(r_idle), 32'd1);
        end
        req = 4'd0; done = 1'b0;

        // Lane 2 fails every attempt, then succeeds on its next grant.
        req = 4'b0100;
        serve(1'b1, 1'b0);
        chk("err_sel",    32'(r_sel),    32'd2);
        chk("err_ack",    32'(r_ack),    32'h4);
        chk("err_flag",   32'(r_err),    32'h4);
        chk("err_starts", 32'(r_starts), 32'd3);
        chk("err_rstrts", 32'(r_rstrts), 32'd2);
        req = 4'd0; done = 1'b0; algn_err = 1'b0;
        @(negedge sclk);
        chk("err_sticky", 32'(err), 32'h4);
        req = 4'b0100;
        serve(1'b0, 1'b0);
        chk("err_regrant_ack", 32'(r_ack), 32'h4);
        chk("err_cleared",     32'(r_err), 32'h0);
        req = 4'd0; done = 1'b0;

        // Hold raised mid-wait: current lane finishes, nothing new starts.
        req = 4'b1001;
        serve(1'b0, 1'b1);
        chk("hold_sel", 32'(r_sel), 32'd3);
        chk("hold_ack", 32'(r_ack), 32'h8);
        req = 4'b0001; done = 1'b0;
        busy_cnt = 0;
        repeat (10) begin
            @(negedge sclk);
            if (busy) busy_cnt++;
        end
        chk("hold_no_grant", 32'(busy_cnt), 32'd0);
        hold = 1'b0;
        serve(1'b0, 1'b0);
        chk("hold_release_sel", 32'(r_sel), 32'd0);
        chk("hold_release_ack", 32'(r_ack), 32'h1);
        req = 4'd0; done = 1'b0;

        // Reset in the middle of a settle, with a sticky error present.
        req = 4'b0100;
        serve(1'b1, 1'b0);
        chk("pre_rst_err", 32'(r_err), 32'h4);
        req = 4'b0010; done = 1'b0; algn_err = 1'b0;
        w = 0;
        while (!busy && w < 20) begin
            @(negedge sclk);
            w++;
        end
        chk("settle_busy", 32'(busy), 32'd1);
        repeat (3) @(negedge sclk);
        rst = 1'b1;
        #1;
        chk_outs_low("mid_rst");
        busy_cnt = 0;
        repeat (3) begin
            @(negedge sclk);
            if (ack != 4'd0) busy_cnt++;
        end
        chk("mid_rst_no_ack", 32'(busy_cnt), 32'd0);
        req = 4'b1001;
        rst = 1'b0;
        serve(1'b0, 1'b0);
        chk("post_rst_sel", 32'(r_sel), 32'd0);
        chk("post_rst_ack", 32'(r_ack), 32'h1);
        req = 4'd0; done = 1'b0;

        // Short timeout instance with the engine never reporting done.
        req2 = 4'b0001;
        starts2 = 0; rstrts2 = 0; t_start = 0; gap = 0; cyc = 0;
        got2 = 1'b0; a2 = 4'd0; e2 = 4'd0;
        while (!got2 && cyc < 400) begin
            @(negedge sclk);
            cyc++;
            if (start2) begin
                starts2++;
                if (starts2 == 1) t_start = cyc;
            end
            if (rstrt2) begin
                rstrts2++;
                if (rstrts2 == 1) gap = cyc - t_start;
            end
            if (ack2 != 4'd0) begin
                got2 = 1'b1;
                a2   = ack2;
                e2   = err2;
                chk("tmo_sel",  32'(sel2),  32'd0);
                chk("tmo_busy", 32'(busy2), 32'd1);
            end
        end
        req2 = 4'd0;
        chk("tmo_ack_seen", 32'(got2),    32'd1);
        chk("tmo_gap",      32'(gap),     32'd16);
        chk("tmo_starts",   32'(starts2), 32'd3);
        chk("tmo_rstrts",   32'(rstrts2), 32'd2);
        chk("tmo_ack",      32'(a2),      32'h1);
        chk("tmo_err",      32'(e2),      32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
